// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded fields and an immediate into an instruction word,
// registered into a 2-entry valid/ready output buffer. Optional macro: INSTR_ENC_RANGE_CHK_EN.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] imm_in,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        err_out
);

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_CSR  = 3'b110;

    // The pointer and count widths below assume exactly two entries.
    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("instr_encoder: DEPTH must be 2");
        end
    endgenerate

    logic [31:0] w_instr;
    logic        w_rsvd_err;
    logic        w_range_err;
    logic        w_err;
    logic        w_push;
    logic        w_pop;

    logic [32:0] r_mem [0:DEPTH-1];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    always_comb begin
        w_instr    = 32'h0000_0000;
        w_rsvd_err = 1'b0;
        unique case (imm_sel)
            IMM_NONE: w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            IMM_I:    w_instr = {imm_in[11:0], rs1, funct3, rd, opcode};
            IMM_S:    w_instr = {imm_in[11:5], rs2, rs1, funct3, imm_in[4:0], opcode};
            IMM_B:    w_instr = {imm_in[12], imm_in[10:5], rs2, rs1, funct3,
                                 imm_in[4:1], imm_in[11], opcode};
            IMM_U:    w_instr = {imm_in[31:12], rd, opcode};
            IMM_J:    w_instr = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12],
                                 rd, opcode};
            // CSR address is {funct7, rs2}; the 5-bit zimm occupies the rs1 slot.
            IMM_CSR:  w_instr = {funct7, rs2, imm_in[4:0], funct3, rd, opcode};
            default:  w_rsvd_err = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHK_EN
    always_comb begin
        w_range_err = 1'b0;
        unique case (imm_sel)
            IMM_I, IMM_S: w_range_err = !((&imm_in[31:11]) || !(|imm_in[31:11]));
            IMM_B:        w_range_err = !((&imm_in[31:12]) || !(|imm_in[31:12])) || imm_in[0];
            IMM_J:        w_range_err = !((&imm_in[31:20]) || !(|imm_in[31:20])) || imm_in[0];
            IMM_U:        w_range_err = |imm_in[11:0];
            IMM_CSR:      w_range_err = |imm_in[31:5];
            default:      w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_err = w_rsvd_err | w_range_err;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage needs no reset; the outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_err, w_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign instr_out = out_valid ? r_mem[r_rptr][31:0] : 32'h0000_0000;
    assign err_out   = out_valid ? r_mem[r_rptr][32]   : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps plus randomized traffic
// scored against a queue-based reference model of the encoder and its 2-entry buffer.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [31:0] imm_in;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        err_out;

    int checks = 0;
    int errors = 0;
    logic [32:0] modelQ [$];

    instr_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .imm_in    (imm_in),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    // Does the signed immediate fit in an n-bit two's complement field?
    function automatic bit fitsSigned(input logic [31:0] v, input int n);
        longint s;
        s = longint'($signed(v));
        return (s >= -(longint'(1) << (n - 1))) && (s < (longint'(1) << (n - 1)));
    endfunction

    function automatic logic [32:0] refEncode(input logic [2:0] sel, input logic [31:0] imm,
                                              input logic [6:0] op, input logic [4:0] fRd,
                                              input logic [4:0] fRs1, input logic [4:0] fRs2,
                                              input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] w;
        bit          e;
        w = 32'(op) + (32'(fRd) << 7);
        e = 1'b0;
        case (sel)
            3'd0: w = 32'(op) + (32'(fRd) << 7) + (32'(f3) << 12) + (32'(fRs1) << 15)
                      + (32'(fRs2) << 20) + (32'(f7) << 25);
            3'd1: begin
                w = w + (32'(f3) << 12) + (32'(fRs1) << 15) + (bits(imm, 11, 0) << 20);
                e = !fitsSigned(imm, 12);
            end
            3'd2: begin
                w = 32'(op) + (bits(imm, 4, 0) << 7) + (32'(f3) << 12) + (32'(fRs1) << 15)
                    + (32'(fRs2) << 20) + (bits(imm, 11, 5) << 25);
                e = !fitsSigned(imm, 12);
            end
            3'd3: begin
                w = 32'(op) + (bits(imm, 11, 11) << 7) + (bits(imm, 4, 1) << 8)
                    + (32'(f3) << 12) + (32'(fRs1) << 15) + (32'(fRs2) << 20)
                    + (bits(imm, 10, 5) << 25) + (bits(imm, 12, 12) << 31);
                e = !fitsSigned(imm, 13) || imm[0];
            end
            3'd4: begin
                w = 32'(op) + (32'(fRd) << 7) + (bits(imm, 31, 12) << 12);
                e = (imm % 4096) != 0;
            end
            3'd5: begin
                w = w + (bits(imm, 19, 12) << 12) + (bits(imm, 11, 11) << 20)
                    + (bits(imm, 10, 1) << 21) + (bits(imm, 20, 20) << 31);
                e = !fitsSigned(imm, 21) || imm[0];
            end
            3'd6: begin
                w = w + (32'(f3) << 12) + (bits(imm, 4, 0) << 15) + (32'(fRs2) << 20)
                    + (32'(f7) << 25);
                e = imm > 32'd31;
            end
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
`ifndef INSTR_ENC_RANGE_CHK_EN
        e = (sel == 3'd7);
`endif
        return {e, w};
    endfunction

    // Immediate generator (B-type) used to check the round trip of an encoded word.
    function automatic logic [31:0] immGenB(input logic [31:0] w);
        logic [12:0] b;
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        return 32'($signed(b));
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        logic [32:0] head;
        head = (modelQ.size() != 0) ? modelQ[0] : 33'h0;
        check1("out_valid", 32'(out_valid), 32'(modelQ.size() != 0));
        check1("in_ready",  32'(in_ready),  32'(modelQ.size() < 2));
        check1("instr_out", instr_out, head[31:0]);
        check1("err_out",   32'(err_out), 32'(head[32]));
    endtask

    // Drive one cycle of inputs at a negedge, advance the model at the posedge, check at the next negedge.
    task automatic applyStimulus(input bit v, input logic [2:0] sel, input logic [31:0] imm,
                                 input logic [6:0] op, input logic [4:0] fRd,
                                 input logic [4:0] fRs1, input logic [4:0] fRs2,
                                 input logic [2:0] f3, input logic [6:0] f7, input bit ordy);
        bit doPush;
        bit doPop;
        in_valid = v; imm_sel = sel; imm_in = imm; opcode = op; rd = fRd;
        rs1 = fRs1; rs2 = fRs2; funct3 = f3; funct7 = f7; out_ready = ordy;
        @(posedge clk);
        doPush = v && (modelQ.size() < 2);
        doPop  = (modelQ.size() != 0) && ordy;
        if (doPop) void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(refEncode(sel, imm, op, fRd, fRs1, fRs2, f3, f7));
        @(negedge clk);
        checkOutput();
    endtask

    task automatic randomStep(input bit v, input bit ordy);
        logic [31:0] imm;
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       imm = 32'($urandom_range(0, 63));
            default: imm = $urandom & 32'hFFFF_F000;
        endcase
        applyStimulus(v, 3'($urandom_range(0, 7)), imm, 7'($urandom), 5'($urandom),
                      5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), ordy);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; imm_sel = 3'd0; imm_in = 32'h0;
        opcode = 7'h0; rd = 5'h0; rs1 = 5'h0; rs2 = 5'h0; funct3 = 3'h0; funct7 = 7'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();

        // I-type, -1
        applyStimulus(1, 3'd1, 32'hFFFF_FFFF, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 1);
        check1("i_type_instr", instr_out, 32'hFFF0_8113);
        check1("i_type_err", 32'(err_out), 32'd0);

        // B-type round trip, -8
        applyStimulus(1, 3'd3, 32'hFFFF_FFF8, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        check1("b_type_instr", instr_out, 32'hFE00_0CE3);
        check1("b_roundtrip", immGenB(instr_out), 32'hFFFF_FFF8);

        // J-type misaligned offset
        applyStimulus(1, 3'd5, 32'h0000_0801, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        check1("j_type_instr", instr_out, 32'h0010_00EF);
`ifdef INSTR_ENC_RANGE_CHK_EN
        check1("j_type_err", 32'(err_out), 32'd1);
`else
        check1("j_type_err", 32'(err_out), 32'd0);
`endif

        // Reserved select and CSR
        applyStimulus(1, 3'd7, 32'h1234_5678, 7'h73, 5'd3, 5'd4, 5'd5, 3'd1, 7'h18, 1);
        check1("rsvd_instr", instr_out, 32'h0);
        check1("rsvd_err", 32'(err_out), 32'd1);
        applyStimulus(1, 3'd6, 32'h0000_0015, 7'h73, 5'd3, 5'd4, 5'd5, 3'd5, 7'h18, 1);
        applyStimulus(0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1);

        // Backpressure: three back-to-back pushes with the consumer stalled
        randomStep(1, 0);
        randomStep(1, 0);
        check1("bp_full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 3'd4, 32'hABCD_E000, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 0);
        applyStimulus(1, 3'd4, 32'hABCD_E000, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        check1("bp_ready_after_pop", 32'(in_ready), 32'd1);
        applyStimulus(1, 3'd4, 32'hABCD_E000, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        applyStimulus(0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1);
        applyStimulus(0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1);

        // Continuous streaming at count 1 across several pointer wraps
        for (int i = 0; i < 24; i++) randomStep(1, 1);

        // Reset with two entries buffered; a concurrent request must be ignored
        randomStep(1, 0);
        randomStep(1, 0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        modelQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        checkOutput();
        applyStimulus(1, 3'd2, 32'hFFFF_FFFC, 7'h23, 5'd0, 5'd7, 5'd8, 3'd2, 7'd0, 0);
        check1("post_reset_count", 32'(modelQ.size()), 32'd1);
        applyStimulus(0, 3'd0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) randomStep($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
